seq101_scan_ctrl: RTL and testbench

Clocked controller that sequences serial "101" pattern detection over the switch word Ks, one bit per clock, LSB first.
A debounced START button launches a scan, and a BUSY/DONE handshake brackets it.
Outputs are per-position hit flags for the LEDs, a hit count, and the count's 7-segment code for the display.
It replaces the level-triggered combinational scan with a deterministic, restartable sequencer on the board clock.

---
 rtl/seq101_pkg.sv | 46 ++++
 rtl/btn_debounce.sv | 56 +++++
 rtl/seq101_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_seq101_scan_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq101_pkg.sv
// Shared types and constants for the serial "101" scan controller.
package seq101_pkg;

    // Controller states, one-hot so each state is a single flop.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SCAN = 3'b010,
        FIN  = 3'b100
    } ctrl_state_e;

    // Detector progress: D0 nothing, D1 seen "1", D2 seen "10".
    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2
    } det_state_e;

    // Seven-segment patterns ordered {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Display code for a hit count; the decimal point is never lit.
    function automatic logic [7:0] seg_encode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            default: seg = SEG_BLANK;
        endcase
        return {seg, 1'b0};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and
// a one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          pulse_q, pulse_d;

    // Accept the synchronised level once it has differed from the current
    // level for DEB_CYCLES consecutive cycles; any glitch back restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser and debouncer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/seq101_scan_ctrl.sv
// Sequenced "101" detector: a debounced START launches a scan of a
// snapshot of Ks, one bit per clock LSB first, with live hit flags/count.
module seq101_scan_ctrl
    import seq101_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             K0,
    input  logic [WIDTH-1:0] Ks,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] FLAGS,
    output logic [3:0]       CNT,
    output logic [7:0]       NUM
);

    localparam int POS_W = $clog2(WIDTH);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);

    logic             start_pulse;

    ctrl_state_e      state_q, state_d;
    det_state_e       det_q,   det_d;
    logic [WIDTH-1:0] ks_q,    ks_d;
    logic             mode_q,  mode_d;
    logic [POS_W-1:0] pos_q,   pos_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic             bit_b;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_start_deb (
        .clk_i  (CLK),
        .rst_i  (RST),
        .btn_i  (START),
        .pulse_o(start_pulse)
    );

    assign bit_b = ks_q[pos_q];

    // Controller and detector next-state; a start while busy is dropped.
    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        ks_d    = ks_q;
        mode_d  = mode_q;
        pos_d   = pos_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    ks_d    = Ks;
                    mode_d  = K0;
                    flags_d = '0;
                    cnt_d   = '0;
                    pos_d   = '0;
                    det_d   = D0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                case (det_q)
                    D0: det_d = bit_b ? D1 : D0;
                    D1: det_d = bit_b ? D1 : D2;
                    D2: begin
                        if (bit_b) begin
                            flags_d[pos_q] = 1'b1;
                            cnt_d          = cnt_q + 4'd1;
                            det_d          = mode_q ? D0 : D1;
                        end else begin
                            det_d = D0;
                        end
                    end
                    default: det_d = D0;
                endcase
                pos_d = pos_q + POS_W'(1);
                if (pos_q == LAST_POS) begin
                    pos_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset wins over a same-cycle start.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            det_q   <= D0;
            ks_q    <= '0;
            mode_q  <= 1'b0;
            pos_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            ks_q    <= ks_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign FLAGS = flags_q;
    assign CNT   = cnt_q;
    assign NUM   = seg_encode(cnt_q);

endmodule

// File: tb/tb_seq101_scan_ctrl.sv
// Randomised, self-checking bench for seq101_scan_ctrl against a
// window-based reference model of "101" detection.
module tb_seq101_scan_ctrl;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic             K0 = 1'b0;
    logic [WIDTH-1:0] Ks = '0;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] FLAGS;
    logic [3:0]       CNT;
    logic [7:0]       NUM;

    int errors = 0;
    int checks = 0;

    logic [6:0] segTab [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};

    seq101_scan_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(DEB)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .START(START),
        .K0   (K0),
        .Ks   (Ks),
        .BUSY (BUSY),
        .DONE (DONE),
        .FLAGS(FLAGS),
        .CNT  (CNT),
        .NUM  (NUM)
    );

    always #5 CLK = ~CLK;

    // Reference: every "101" window ending at p is a hit when overlapping;
    // non-overlapping takes windows greedily, each starting after the last hit.
    function automatic logic [7:0] refFlags(input logic [7:0] ks, input logic k0);
        logic [7:0] f = '0;
        int lastEnd = -1;
        for (int p = 2; p < WIDTH; p++) begin
            if (ks[p] && !ks[p-1] && ks[p-2] && (!k0 || (p - 2 > lastEnd))) begin
                f[p] = 1'b1;
                lastEnd = p;
            end
        end
        return f;
    endfunction

    function automatic logic [7:0] refNum(input int n);
        return (n < 8) ? {segTab[n], 1'b0} : 8'h00;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic releaseStart();
        START = 1'b0;
        waitCycles(DEB + 6);
    endtask

    // Launch a scan and measure latency, BUSY length and DONE behaviour.
    task automatic applyStimulus(input logic [7:0] ks, input logic k0,
                                 output int latency, output int busyLen,
                                 output logic doneFirst, output int doneLen);
        Ks = ks;
        K0 = k0;
        START = 1'b1;
        latency = 0;
        do begin
            @(negedge CLK);
            latency++;
        end while (!BUSY && latency < 30);
        START = 1'b0;
        busyLen = 0;
        while (BUSY && busyLen < 40) begin
            busyLen++;
            @(negedge CLK);
        end
        doneFirst = DONE;
        doneLen = 0;
        for (int i = 0; i < 4; i++) begin
            if (DONE) doneLen++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        waitCycles(3);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({BUSY, DONE, FLAGS, CNT, NUM} !== {1'b0, 1'b0, 8'h00, 4'h0, 8'hFC}) begin
            errors++;
            $display("[TB] FAIL reset: got BUSY=%b DONE=%b FLAGS=%h CNT=%0d NUM=%h, want 0 0 00 0 fc",
                     BUSY, DONE, FLAGS, CNT, NUM);
        end
    endtask

    task automatic test_basic();
        int lat, bl, dl;
        logic df;
        applyStimulus(8'h05, 1'b0, lat, bl, df, dl);
        checks++;
        if (lat < DEB + 2 || lat > DEB + 4) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d cycles, want %0d..%0d", lat, DEB + 2, DEB + 4);
        end
        checks++;
        if (bl !== WIDTH) begin
            errors++;
            $display("[TB] FAIL basic_busy_len: got %0d, want %0d", bl, WIDTH);
        end
        checks++;
        if (df !== 1'b1 || dl !== 1) begin
            errors++;
            $display("[TB] FAIL basic_done: got first=%b len=%0d, want 1 1", df, dl);
        end
        checks++;
        if ({FLAGS, CNT, NUM} !== {8'h04, 4'd1, 8'h60}) begin
            errors++;
            $display("[TB] FAIL basic_result: got %h/%0d/%h, want 04/1/60", FLAGS, CNT, NUM);
        end
        releaseStart();
    endtask

    task automatic test_modes();
        int lat, bl, dl;
        logic df;
        logic [7:0] wantF [2] = '{8'h14, 8'h04};
        logic [3:0] wantC [2] = '{4'd2, 4'd1};
        logic [7:0] wantN [2] = '{8'hDA, 8'h60};
        for (int m = 0; m < 2; m++) begin
            applyStimulus(8'h15, m[0], lat, bl, df, dl);
            checks++;
            if ({FLAGS, CNT, NUM} !== {wantF[m], wantC[m], wantN[m]}) begin
                errors++;
                $display("[TB] FAIL mode%0d_result: got %h/%0d/%h, want %h/%0d/%h",
                         m, FLAGS, CNT, NUM, wantF[m], wantC[m], wantN[m]);
            end
            releaseStart();
        end
    endtask

    // Flags/count should reveal positions as they are processed.
    task automatic test_live_update();
        logic [7:0] full = refFlags(8'h55, 1'b0);
        logic [7:0] want;
        int n = 0;
        Ks = 8'h55;
        K0 = 1'b0;
        START = 1'b1;
        while (!BUSY && n < 30) begin
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            want = full & 8'((1 << (k - 1)) - 1);
            checks++;
            if (FLAGS !== want || CNT !== 4'($countones(want)) || BUSY !== 1'b1) begin
                errors++;
                $display("[TB] FAIL live_cycle%0d: got FLAGS=%h CNT=%0d BUSY=%b, want %h %0d 1",
                         k, FLAGS, CNT, BUSY, want, $countones(want));
            end
            @(negedge CLK);
        end
        checks++;
        if ({FLAGS, CNT, NUM} !== {8'h54, 4'd3, 8'hF2}) begin
            errors++;
            $display("[TB] FAIL live_final: got %h/%0d/%h, want 54/3/f2", FLAGS, CNT, NUM);
        end
        releaseStart();
    endtask

    task automatic test_bounce();
        logic [7:0] prevF = FLAGS;
        logic [3:0] prevC = CNT;
        logic sawBusy = 1'b0;
        int lat, bl, dl;
        logic df;
        START = 1'b1; waitCycles(2);
        START = 1'b0; waitCycles(1);
        START = 1'b1; waitCycles(3);
        START = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (BUSY) sawBusy = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (sawBusy !== 1'b0 || FLAGS !== prevF || CNT !== prevC) begin
            errors++;
            $display("[TB] FAIL bounce_ignored: got busy=%b FLAGS=%h CNT=%0d, want 0 %h %0d",
                     sawBusy, FLAGS, CNT, prevF, prevC);
        end
        applyStimulus(8'h15, 1'b0, lat, bl, df, dl);
        checks++;
        if (bl !== WIDTH || FLAGS !== 8'h14) begin
            errors++;
            $display("[TB] FAIL bounce_then_launch: got busyLen=%0d FLAGS=%h, want %0d 14", bl, FLAGS, WIDTH);
        end
        releaseStart();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic sawBusy = 1'b0;
        Ks = 8'h55;
        K0 = 1'b0;
        START = 1'b1;
        while (!BUSY && n < 30) begin
            @(negedge CLK);
            n++;
        end
        Ks = 8'h00;
        K0 = 1'b1;
        n = 0;
        while (BUSY && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if ({FLAGS, CNT, NUM} !== {8'h54, 4'd3, 8'hF2}) begin
            errors++;
            $display("[TB] FAIL snapshot_result: got %h/%0d/%h, want 54/3/f2", FLAGS, CNT, NUM);
        end
        for (int i = 0; i < 20; i++) begin
            if (BUSY) sawBusy = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (sawBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_start_retrigger: got busy=%b, want 0", sawBusy);
        end
        START = 1'b0;
        waitCycles(DEB + 4);
        START = 1'b1;
        n = 0;
        while (!BUSY && n < 30) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("[TB] FAIL relaunch_after_release: got BUSY=%b, want 1", BUSY);
        end
        releaseStart();
    endtask

    task automatic test_abort();
        int n = 0;
        logic sawAny = 1'b0;
        Ks = 8'h55;
        K0 = 1'b0;
        START = 1'b1;
        while (!BUSY && n < 30) begin
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        waitCycles(3);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({BUSY, DONE, FLAGS, CNT, NUM} !== {1'b0, 1'b0, 8'h00, 4'h0, 8'hFC}) begin
            errors++;
            $display("[TB] FAIL abort_reset: got BUSY=%b DONE=%b FLAGS=%h CNT=%0d NUM=%h, want 0 0 00 0 fc",
                     BUSY, DONE, FLAGS, CNT, NUM);
        end
        for (int i = 0; i < 14; i++) begin
            if (DONE || BUSY) sawAny = 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (sawAny !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got activity=%b, want 0", sawAny);
        end
    endtask

    task automatic checkOutput(input logic [7:0] ks, input logic k0, input int bl);
        logic [7:0] wf = refFlags(ks, k0);
        int wc = $countones(wf);
        checks++;
        if (FLAGS !== wf || CNT !== 4'(wc) || NUM !== refNum(wc) || bl !== WIDTH) begin
            errors++;
            $display("[TB] FAIL random ks=%h k0=%b: got %h/%0d/%h len=%0d, want %h/%0d/%h len=%0d",
                     ks, k0, FLAGS, CNT, NUM, bl, wf, wc, refNum(wc), WIDTH);
        end
    endtask

    task automatic test_random();
        int lat, bl, dl;
        logic df;
        logic [7:0] ks;
        logic k0;
        for (int t = 0; t < 12; t++) begin
            ks = 8'($urandom);
            k0 = 1'($urandom);
            applyStimulus(ks, k0, lat, bl, df, dl);
            checkOutput(ks, k0, bl);
            releaseStart();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_live_update();
        test_bounce();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
